// File: rtl/led_display_scan_ctrl.sv
// rtl/led_display_scan_ctrl.sv - LED panel scan controller; optional blanking guard via LED_DISPLAY_SCAN_BLANK_EN
module led_display_scan_ctrl #(
    parameter int NUM_ROW_PIXELS = 32,
    parameter int NUM_COL_PIXELS = 64,
    parameter int DISPLAY_CYCLES = 256,
    parameter int BLANK_CYCLES   = 4,
    localparam int ROW_W = $clog2(NUM_ROW_PIXELS / 2),
    localparam int COL_W = $clog2(NUM_COL_PIXELS)
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   enable_in,
    output logic [ROW_W+COL_W-1:0] ram_addr_out,
    input  logic [5:0]             ram_data_in,
    output logic [2:0]             rgb_top_out,
    output logic [2:0]             rgb_bot_out,
    output logic                   bclk_out,
    output logic                   latch_out,
    output logic                   oe_n_out,
    output logic [ROW_W-1:0]       row_addr_out,
    output logic                   frame_done_out
);
    localparam int SHIFT_CYCLES = 2 * NUM_COL_PIXELS;
    localparam int MAX_A        = (SHIFT_CYCLES > DISPLAY_CYCLES) ? SHIFT_CYCLES : DISPLAY_CYCLES;
    localparam int CNT_MAX      = (MAX_A > BLANK_CYCLES) ? MAX_A : BLANK_CYCLES;
    localparam int CNT_W        = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SHIFT_LAST   = CNT_W'(SHIFT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DISPLAY_LAST = CNT_W'(DISPLAY_CYCLES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(NUM_ROW_PIXELS / 2 - 1);
    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(NUM_COL_PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PREFETCH,
        SHIFT,
        LATCH,
        BLANK,
        DISPLAY
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  col_next;
    logic              disp_last;

    // Within SHIFT the phase counter encodes {column, half-bit}.
    assign col       = cnt[COL_W:1];
    assign col_next  = (col == COL_LAST) ? '0 : col + COL_W'(1);
    assign disp_last = (state == DISPLAY) && (cnt == DISPLAY_LAST);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        bclk_out       = 1'b0;
        latch_out      = 1'b0;
        oe_n_out       = 1'b1;
        frame_done_out = 1'b0;
        ram_addr_out   = {row, COL_W'(0)};
        case (state)
            IDLE: begin
                if (enable_in) begin
                    next_state = PREFETCH;
                end
            end
            PREFETCH: begin
                next_state = SHIFT;
            end
            SHIFT: begin
                bclk_out     = cnt[0];
                ram_addr_out = {row, cnt[0] ? col_next : col};
                if (cnt == SHIFT_LAST) begin
                    next_state = LATCH;
                end
            end
            LATCH: begin
                latch_out = 1'b1;
`ifdef LED_DISPLAY_SCAN_BLANK_EN
                next_state = BLANK;
`else
                next_state = DISPLAY;
`endif
            end
            BLANK: begin
                if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    next_state = DISPLAY;
                end
            end
            DISPLAY: begin
                oe_n_out = 1'b0;
                if (cnt == DISPLAY_LAST) begin
                    frame_done_out = (row == ROW_LAST);
                    next_state     = enable_in ? PREFETCH : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Every state exits at a phase boundary, so a state change restarts the phase count.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            cnt          <= '0;
            row          <= '0;
            rgb_top_out  <= '0;
            rgb_bot_out  <= '0;
            row_addr_out <= '0;
        end else begin
            if (next_state != state) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (state == SHIFT && !cnt[0]) begin
                rgb_top_out <= ram_data_in[5:3];
                rgb_bot_out <= ram_data_in[2:0];
            end

            if (disp_last) begin
                if (!enable_in || row == ROW_LAST) begin
                    row <= '0;
                end else begin
                    row <= row + ROW_W'(1);
                end
            end

`ifdef LED_DISPLAY_SCAN_BLANK_EN
            if (state == LATCH) begin
                row_addr_out <= row;
            end
`else
            if (state == SHIFT && next_state == LATCH) begin
                row_addr_out <= row;
            end
`endif
        end
    end
endmodule

// File: tb/tb_led_display_scan_ctrl.sv
// tb/tb_led_display_scan_ctrl.sv - directed self-checking bench for led_display_scan_ctrl (default build)
module tb_led_display_scan_ctrl;
    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       enable_in;
    logic [9:0] ram_addr_out;
    logic [5:0] ram_data_in = 6'd0;
    logic [2:0] rgb_top_out;
    logic [2:0] rgb_bot_out;
    logic       bclk_out;
    logic       latch_out;
    logic       oe_n_out;
    logic [3:0] row_addr_out;
    logic       frame_done_out;

    int checks   = 0;
    int failures = 0;

    led_display_scan_ctrl dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .enable_in      (enable_in),
        .ram_addr_out   (ram_addr_out),
        .ram_data_in    (ram_data_in),
        .rgb_top_out    (rgb_top_out),
        .rgb_bot_out    (rgb_bot_out),
        .bclk_out       (bclk_out),
        .latch_out      (latch_out),
        .oe_n_out       (oe_n_out),
        .row_addr_out   (row_addr_out),
        .frame_done_out (frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    // Frame RAM: data is the column index, returned one cycle after the address.
    always @(posedge clk_in) ram_data_in <= ram_addr_out[5:0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    int         cyc         = 0;
    int         edges       = 0;
    int         exp_row     = 0;
    int         disp_len    = 0;
    int         latch_cnt   = 0;
    int         fd_cnt      = 0;
    int         oe_low_cnt  = 0;
    int         last_fd_cyc = 0;
    int         prev_fd_cyc = 0;
    logic       en_last     = 1'b0;
    logic       prev_bclk   = 1'b0;
    logic       prev_latch  = 1'b0;
    logic       prev_oe_n   = 1'b1;
    logic [3:0] prev_row    = 4'd0;

    always @(negedge clk_in) begin
        cyc++;
        if (reset_in) begin
            edges    = 0;
            exp_row  = 0;
            disp_len = 0;
        end else begin
            check("oe_with_latch", 32'(!oe_n_out && latch_out), 32'd0);
            check("row_change_while_lit", 32'(!oe_n_out && (row_addr_out != prev_row)), 32'd0);
            if (bclk_out && !prev_bclk) begin
                check("rgb_at_rise", 32'({rgb_top_out, rgb_bot_out}), 32'(edges));
                edges++;
            end
            if (latch_out) begin
                check("latch_width", 32'(prev_latch), 32'd0);
                check("bclk_edges_per_row", 32'(edges), 32'd64);
                check("row_addr_at_latch", 32'(row_addr_out), 32'(exp_row));
                edges = 0;
                latch_cnt++;
            end
            if (!oe_n_out) begin
                disp_len++;
                oe_low_cnt++;
                en_last = enable_in;
            end
            if (oe_n_out && !prev_oe_n) begin
                check("display_len", 32'(disp_len), 32'd256);
                disp_len = 0;
                exp_row  = en_last ? (exp_row + 1) % 16 : 0;
            end
            if (frame_done_out) begin
                check("frame_done_row", 32'({oe_n_out, row_addr_out}), 32'd15);
                fd_cnt++;
                prev_fd_cyc = last_fd_cyc;
                last_fd_cyc = cyc;
            end
        end
        prev_bclk  = bclk_out;
        prev_latch = latch_out;
        prev_oe_n  = oe_n_out;
        prev_row   = row_addr_out;
    end

    task automatic wait_frame_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_in);
            if (frame_done_out) ok = 1'b1;
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_latch(input int budget, output bit ok, output int waited, output logic [3:0] row);
        ok     = 1'b0;
        waited = 0;
        row    = 4'd0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_in);
            waited++;
            if (latch_out) begin
                ok  = 1'b1;
                row = row_addr_out;
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_oe(input logic level, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_in);
            if (oe_n_out == level) ok = 1'b1;
        end
        @(posedge clk_in);
        #1;
    endtask

    bit         ok;
    int         waited;
    int         lc0;
    int         fd0;
    int         ol0;
    logic [3:0] lrow;

    initial begin
        reset_in  = 1'b1;
        enable_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_oe_n", 32'(oe_n_out), 32'd1);
        check("rst_bclk", 32'(bclk_out), 32'd0);
        check("rst_latch", 32'(latch_out), 32'd0);
        check("rst_frame_done", 32'(frame_done_out), 32'd0);
        check("rst_ram_addr", 32'(ram_addr_out), 32'd0);
        check("rst_rgb", 32'({rgb_top_out, rgb_bot_out}), 32'd0);
        check("rst_row_addr", 32'(row_addr_out), 32'd0);

        reset_in = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        check("idle_oe_n", 32'(oe_n_out), 32'd1);
        check("idle_bclk", 32'(bclk_out), 32'd0);
        check("idle_no_latch", 32'(latch_cnt), 32'd0);

        // Full frames: 16 rows of 1 + 128 + 1 + 256 cycles.
        lc0       = latch_cnt;
        fd0       = fd_cnt;
        enable_in = 1'b1;
        wait_frame_done(7000, ok);
        check("frame1_seen", 32'(ok), 32'd1);
        check("frame1_latches", 32'(latch_cnt - lc0), 32'd16);
        check("frame1_pulses", 32'(fd_cnt - fd0), 32'd1);
        wait_frame_done(7000, ok);
        check("frame2_seen", 32'(ok), 32'd1);
        check("frame_period", 32'(last_fd_cyc - prev_fd_cyc), 32'd6176);
        check("frame2_latches", 32'(latch_cnt - lc0), 32'd32);

        // Drop enable while row 5 is shifting.
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk_in);
            if (bclk_out && ram_addr_out[9:6] == 4'd5) ok = 1'b1;
        end
        @(posedge clk_in);
        #1;
        check("row5_shift_seen", 32'(ok), 32'd1);
        enable_in = 1'b0;
        wait_oe(1'b0, 300, ok);
        check("row5_display_start", 32'(ok), 32'd1);
        check("row5_row_addr", 32'(row_addr_out), 32'd5);
        wait_oe(1'b1, 300, ok);
        check("row5_display_end", 32'(ok), 32'd1);
        lc0 = latch_cnt;
        fd0 = fd_cnt;
        ol0 = oe_low_cnt;
        repeat (400) @(posedge clk_in);
        #1;
        check("idle_no_display", 32'(oe_low_cnt - ol0), 32'd0);
        check("idle_no_latches", 32'(latch_cnt - lc0), 32'd0);
        check("idle_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
        check("idle_ram_addr", 32'(ram_addr_out), 32'd0);

        enable_in = 1'b1;
        wait_latch(300, ok, waited, lrow);
        check("restart_latch_seen", 32'(ok), 32'd1);
        check("restart_latency", 32'(waited), 32'd131);
        check("restart_row", 32'(lrow), 32'd0);

        // Asynchronous reset in the middle of row 9 display.
        lrow = 4'd0;
        for (int i = 0; i < 12 && lrow != 4'd9; i++) begin
            wait_latch(500, ok, waited, lrow);
        end
        check("row9_latch_seen", 32'(lrow), 32'd9);
        repeat (100) @(posedge clk_in);
        #1;
        check("row9_lit", 32'(oe_n_out), 32'd0);
        #2;
        reset_in = 1'b1;
        #1;
        check("async_oe_n", 32'(oe_n_out), 32'd1);
        check("async_row_addr", 32'(row_addr_out), 32'd0);
        check("async_ram_addr", 32'(ram_addr_out), 32'd0);
        check("async_rgb", 32'({rgb_top_out, rgb_bot_out}), 32'd0);
        check("async_strobes", 32'({bclk_out, latch_out, frame_done_out}), 32'd0);
        @(posedge clk_in);
        #1;
        reset_in = 1'b0;
        wait_latch(300, ok, waited, lrow);
        check("post_reset_latch_seen", 32'(ok), 32'd1);
        check("post_reset_row", 32'(lrow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
